// File: rtl/dds_sweep_ctrl.sv
// Stepped frequency-sweep sequencer for the DDS phase increment (single, sawtooth, triangle).
// Optional SWEEP_HOLD_EN adds a hold input that freezes the dwell countdown.
module dds_sweep_ctrl #(
  parameter int unsigned INC_W   = 32,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
`ifdef SWEEP_HOLD_EN
  input  logic               hold,
`endif
  input  logic [1:0]         mode,
  input  logic [INC_W-1:0]   f_start,
  input  logic [INC_W-1:0]   f_stop,
  input  logic [INC_W-1:0]   step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [INC_W-1:0]   inc_out,
  output logic               sync_out,
  output logic               busy,
  output logic               done,
  output logic               dir
);

  typedef enum logic [1:0] {IDLE, DWELL, STEP} state_t;

  state_t               state, state_n;
  logic [1:0]           mode_q;
  logic [INC_W-1:0]     fs_q, fe_q, st_q;
  logic [DWELL_W-1:0]   dw_q, cnt_q, cnt_n;
  logic                 degen_q, latch;
  logic [INC_W-1:0]     inc_n;
  logic                 sync_n, busy_n, done_n, dir_n;
  logic                 hold_act;
  logic                 single_mode;
  logic [INC_W:0]       up_sum, dn_lim;
  logic [INC_W-1:0]     up_val, dn_val;

`ifdef SWEEP_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  // Extra MSB keeps the clamp comparisons exact when inc+step overflows INC_W.
  assign up_sum = {1'b0, inc_out} + {1'b0, st_q};
  assign up_val = (up_sum >= {1'b0, fe_q}) ? fe_q : up_sum[INC_W-1:0];
  assign dn_lim = {1'b0, fs_q} + {1'b0, st_q};
  assign dn_val = ({1'b0, inc_out} <= dn_lim) ? fs_q : inc_out - st_q;

  assign single_mode = (mode_q != 2'd1) && (mode_q != 2'd2);

  always_comb begin
    state_n = state;
    inc_n   = inc_out;
    cnt_n   = cnt_q;
    dir_n   = dir;
    busy_n  = busy;
    done_n  = 1'b0;
    sync_n  = 1'b0;
    latch   = 1'b0;
    if (stop) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      dir_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            latch   = 1'b1;
            state_n = DWELL;
            inc_n   = f_start;
            sync_n  = 1'b1;
            busy_n  = 1'b1;
            dir_n   = 1'b0;
            cnt_n   = '0;
          end
        end
        DWELL: begin
          if (!hold_act) begin
            if (cnt_q != dw_q) begin
              cnt_n = cnt_q + DWELL_W'(1);
            end else begin
              // The STEP decision is resolved here so the new value lands on the
              // very next cycle; the registered state never lingers in STEP.
              cnt_n = '0;
              if (!dir) begin
                if (degen_q || (inc_out == fe_q && single_mode)) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  dir_n   = 1'b0;
                end else if (inc_out == fe_q) begin
                  if (mode_q == 2'd1) begin
                    inc_n  = fs_q;
                    sync_n = 1'b1;
                  end else begin
                    dir_n = 1'b1;
                    inc_n = dn_val;
                  end
                end else begin
                  inc_n = up_val;
                end
              end else if (inc_out == fs_q) begin
                dir_n = 1'b0;
                inc_n = up_val;
              end else begin
                inc_n = dn_val;
              end
            end
          end
        end
        STEP: state_n = DWELL;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      inc_out  <= '0;
      sync_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dir      <= 1'b0;
      cnt_q    <= '0;
      mode_q   <= '0;
      fs_q     <= '0;
      fe_q     <= '0;
      st_q     <= '0;
      dw_q     <= '0;
      degen_q  <= 1'b0;
    end else begin
      state    <= state_n;
      inc_out  <= inc_n;
      sync_out <= sync_n;
      busy     <= busy_n;
      done     <= done_n;
      dir      <= dir_n;
      cnt_q    <= cnt_n;
      if (latch) begin
        mode_q  <= mode;
        fs_q    <= f_start;
        fe_q    <= f_stop;
        st_q    <= step;
        dw_q    <= dwell;
        degen_q <= (f_stop <= f_start) || (step == '0);
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed scenarios plus randomized sweeps
// compared cycle by cycle against a level-list reference model.
module tb_dds_sweep_ctrl;
  localparam int INC_W   = 32;
  localparam int DWELL_W = 16;

  logic               clk = 1'b0;
  logic               rst, start, stop;
`ifdef SWEEP_HOLD_EN
  logic               hold;
`endif
  logic [1:0]         mode;
  logic [INC_W-1:0]   f_start, f_stop, step;
  logic [DWELL_W-1:0] dwell;
  logic [INC_W-1:0]   inc_out;
  logic               sync_out, busy, done, dir;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.INC_W(INC_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef SWEEP_HOLD_EN
    .hold(hold),
`endif
    .mode(mode), .f_start(f_start), .f_stop(f_stop), .step(step), .dwell(dwell),
    .inc_out(inc_out), .sync_out(sync_out), .busy(busy), .done(done), .dir(dir)
  );

  typedef struct packed {
    logic [31:0] inc;
    logic        sync;
    logic        busy;
    logic        done;
    logic        dir;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        lv_q[$];
  int          n_pass = 0;
  int          n_chk  = 0;
  logic [31:0] last_inc = '0;

  function automatic obs_t mk(input longint v, input bit s, input bit b, input bit dn, input bit d);
    obs_t o;
    o.inc  = v[31:0];
    o.sync = s;
    o.busy = b;
    o.done = dn;
    o.dir  = d;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.inc  = inc_out;
    o.sync = sync_out;
    o.busy = busy;
    o.done = done;
    o.dir  = dir;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t expv);
    n_chk += 1;
    assert (got === expv) n_pass += 1;
    else $error("FAIL %s: got inc=%0d sync=%b busy=%b done=%b dir=%b, expected inc=%0d sync=%b busy=%b done=%b dir=%b",
                tag, got.inc, got.sync, got.busy, got.done, got.dir,
                expv.inc, expv.sync, expv.busy, expv.done, expv.dir);
  endtask

  // Levels climbing from fs to fe, clamped at fe.
  function automatic void add_up(input longint fs, input longint fe, input longint st,
                                 input bit skip_first, input bit sync_first);
    longint v = fs;
    if (!skip_first) lv_q.push_back(mk(v, sync_first, 1'b1, 1'b0, 1'b0));
    while (v != fe) begin
      v = (v + st >= fe) ? fe : v + st;
      lv_q.push_back(mk(v, 1'b0, 1'b1, 1'b0, 1'b0));
    end
  endfunction

  // Levels falling from fe to fs, clamped at fs.
  function automatic void add_down(input longint fs, input longint fe, input longint st);
    longint v = fe;
    do begin
      v = (v <= fs + st) ? fs : v - st;
      lv_q.push_back(mk(v, 1'b0, 1'b1, 1'b0, 1'b1));
    end while (v != fs);
  endfunction

  // Expected observations for cycles 1..n after start is sampled.
  function automatic void build_exp(input logic [1:0] md, input longint fs, input longint fe,
                                    input longint st, input int dw, input int n);
    bit   deg  = (fe <= fs) || (st == 0);
    bit   sngl = deg || (md == 2'd0) || (md == 2'd3);
    obs_t last;
    lv_q.delete();
    exp_q.delete();
    if (deg) lv_q.push_back(mk(fs, 1'b1, 1'b1, 1'b0, 1'b0));
    else add_up(fs, fe, st, 1'b0, 1'b1);
    if (!sngl && md == 2'd1) begin
      while (lv_q.size() < n) add_up(fs, fe, st, 1'b0, 1'b1);
    end else if (!sngl) begin
      while (lv_q.size() < n) begin
        add_down(fs, fe, st);
        add_up(fs, fe, st, 1'b1, 1'b0);
      end
    end
    foreach (lv_q[i]) begin
      for (int k = 0; k <= dw; k++) begin
        obs_t o = lv_q[i];
        if (k > 0) o.sync = 1'b0;
        exp_q.push_back(o);
      end
      if (exp_q.size() >= n) break;
    end
    if (sngl) begin
      last = lv_q[lv_q.size()-1];
      exp_q.push_back(mk(longint'(last.inc), 1'b0, 1'b0, 1'b1, 1'b0));
      while (exp_q.size() < n) exp_q.push_back(mk(longint'(last.inc), 1'b0, 1'b0, 1'b0, 1'b0));
    end
    while (exp_q.size() > n) void'(exp_q.pop_back());
  endfunction

  task automatic idle_checks(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      check(tag, observe(), mk(longint'(last_inc), 1'b0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic abort_and_check(input string tag);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check(tag, observe(), mk(longint'(last_inc), 1'b0, 1'b0, 1'b0, 1'b0));
    idle_checks(tag, 2);
  endtask

  task automatic run_sweep(input string tag, input logic [1:0] md, input logic [31:0] fs,
                           input logic [31:0] fe, input logic [31:0] st, input logic [15:0] dw,
                           input int n, input int poke_at, input int hold_at);
    build_exp(md, longint'(fs), longint'(fe), longint'(st), int'(dw), n);
`ifdef SWEEP_HOLD_EN
    if (hold_at > 0) repeat (4) exp_q.insert(hold_at - 1, exp_q[hold_at - 1]);
`endif
    mode = md; f_start = fs; f_stop = fe; step = st; dwell = dw;
    start = 1'b1;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check(tag, observe(), exp_q[c-1]);
      if (c == poke_at) begin
        start   = 1'b1;
        mode    = md ^ 2'b11;
        f_start = fs + 32'd7;
        f_stop  = fe + 32'd50;
        step    = st + 32'd3;
        dwell   = dw + 16'd1;
      end
`ifdef SWEEP_HOLD_EN
      hold = (hold_at > 0) && (c >= hold_at) && (c < hold_at + 4);
`else
      if (hold_at > 0 && c == 1) $display("note: hold scenario runs without hold port");
`endif
    end
    last_inc = exp_q[exp_q.size()-1].inc;
    abort_and_check({tag, "_stop"});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
`ifdef SWEEP_HOLD_EN
    hold = 1'b0;
`endif
    mode = '0; f_start = '0; f_stop = '0; step = '0; dwell = '0;
    #1;
    check("reset", observe(), mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
    #12 rst = 1'b0;
    idle_checks("post_reset_idle", 2);

    run_sweep("single",   2'd0, 32'd100, 32'd130, 32'd10, 16'd2, 16, 0, 0);
    run_sweep("clamp",    2'd0, 32'd100, 32'd130, 32'd25, 16'd0, 6, 0, 0);
    run_sweep("triangle", 2'd2, 32'd100, 32'd130, 32'd10, 16'd0, 14, 0, 0);
    run_sweep("sawtooth", 2'd1, 32'd100, 32'd130, 32'd10, 16'd0, 12, 0, 0);
    run_sweep("mode3",    2'd3, 32'd100, 32'd130, 32'd10, 16'd1, 12, 0, 0);
    run_sweep("degen",    2'd2, 32'd130, 32'd100, 32'd10, 16'd1, 5, 0, 0);
    run_sweep("ovf_up",   2'd2, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'h0000_00A0, 16'd0, 12, 0, 0);
    run_sweep("ovf_dn",   2'd2, 32'hFFFF_FF80, 32'hFFFF_FFF0, 32'h0000_00A0, 16'd1, 12, 0, 0);
    run_sweep("abort5",   2'd0, 32'd100, 32'd130, 32'd10, 16'd2, 5, 0, 0);
    run_sweep("start_ignored", 2'd0, 32'd100, 32'd130, 32'd10, 16'd2, 16, 1, 0);
`ifdef SWEEP_HOLD_EN
    run_sweep("hold",     2'd0, 32'd100, 32'd130, 32'd10, 16'd2, 16, 0, 5);
`endif

    mode = 2'd0; f_start = 32'd100; f_stop = 32'd130; step = 32'd10; dwell = 16'd2;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    check("start_stop", observe(), mk(longint'(last_inc), 1'b0, 1'b0, 1'b0, 1'b0));
    idle_checks("start_stop_idle", 2);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("pre_reset", observe(), mk(100, 1'b1, 1'b1, 1'b0, 1'b0));
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_reset", observe(), mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
    #1 rst = 1'b0;
    last_inc = '0;
    idle_checks("after_reset_idle", 2);
    run_sweep("after_reset", 2'd0, 32'd100, 32'd130, 32'd10, 16'd2, 16, 0, 0);

    for (int it = 0; it < 12; it++) begin
      logic [1:0]  md;
      logic [31:0] fs, fe, st;
      logic [15:0] dw;
      int          r;
      md = 2'($urandom_range(0, 3));
      fs = $urandom_range(0, 5000);
      fe = fs + $urandom_range(1, 300);
      st = $urandom_range(1, 120);
      dw = 16'($urandom_range(0, 3));
      r  = $urandom_range(0, 7);
      if (r == 0) fe = fs;
      if (r == 1) st = '0;
      run_sweep("random", md, fs, fe, st, dw, $urandom_range(20, 60), 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Sequencer that drives the phase-increment (frequency) input and the accumulator sync of the DDS used for OPO cavity scanning and lock acquisition.
- Produces stepped frequency sweeps between a start and a stop increment: single-shot, sawtooth (repeating) or triangle (up/down) ramps.
- Each step has a programmable dwell time.
- Sits between the lock-control register bank and the DDS core.

Parameters:
- INC_W, 32, width of frequency increment words (matches DDS phase accumulator increment).
- DWELL_W, 16, width of dwell counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep; ignored while busy.
- stop  in  1  abort; returns the block to idle.
- mode  in  2  0 = single, 1 = sawtooth, 2 = triangle, 3 = treated as single.
- f_start  in  INC_W  lower sweep increment.
- f_stop  in  INC_W  upper sweep increment.
- step  in  INC_W  increment added or subtracted per step.
- dwell  in  DWELL_W  cycles per step minus one.
- inc_out  out  INC_W  increment to the DDS.
- sync_out  out  1  one-cycle accumulator phase-reset pulse to the DDS.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when a single sweep completes.
- dir  out  1  0 = ramping up, 1 = ramping down.

Behaviour:
- Reset (asynchronous) sets outputs to: inc_out = 0, sync_out = 0, busy = 0, done = 0, dir = 0; FSM = IDLE; internal counters = 0.
- FSM states are IDLE, DWELL, STEP.
- Config latch: mode, f_start, f_stop, step and dwell are latched in the cycle start is sampled in IDLE. Input changes during a sweep have no effect.
- Sweep start: if start is sampled at cycle N, then at cycle N+1 inc_out = f_start, sync_out = 1 for that one cycle, busy = 1, dir = 0, and the FSM enters DWELL.
- DWELL: each step value is held for dwell+1 cycles; dwell = 0 gives one cycle per step. When the count expires, the FSM goes to STEP.
- STEP takes zero extra cycles: the new inc_out appears in the cycle immediately after the last dwell cycle.
- Up step: compute the sum in INC_W+1 bits. If inc+step >= f_stop, then inc_out = f_stop (clamped, no wrap). Otherwise inc_out = inc+step.
- Down step: if inc <= f_start+step (INC_W+1 compare), then inc_out = f_start. Otherwise inc_out = inc-step.
- End of a dwell at f_stop while dir = 0:
  - single: the next cycle has busy = 0 and done = 1 for one cycle; inc_out holds f_stop; FSM goes to IDLE.
  - sawtooth: inc_out = f_start with sync_out = 1.
  - triangle: dir = 1 and a down step is applied.
- End of a dwell at f_start while dir = 1 (triangle only): dir = 0 and an up step is applied. No sync pulse is generated.
- Degenerate config (f_stop <= f_start, or step = 0): f_start is held for one dwell period, then the block completes as in single mode for every mode value.
- stop: in any state, the next cycle has busy = 0, FSM = IDLE, and done, sync_out and dir all 0. inc_out holds its last value.
- Simultaneous start and stop: stop wins and the sweep does not start.
- start while busy: ignored.
- Reset mid-sweep: immediate return to reset values.

Optional Feature:
- Macro SWEEP_HOLD_EN.
- When defined: extra input port hold (1 bit). While hold = 1 in DWELL, the dwell counter freezes and inc_out does not change. Releasing hold resumes with the remaining dwell count. stop still overrides hold.
- When undefined: the hold port does not exist and dwell always counts freely.

Test Plan:
- Single sweep: f_start = 100, f_stop = 130, step = 10, dwell = 2, mode = 0, start at cycle 0.
  - inc_out is 100 in cycles 1-3, 110 in 4-6, 120 in 7-9, 130 in 10-12.
  - sync_out = 1 in cycle 1 only; done = 1 and busy = 0 in cycle 13; inc_out stays 130.
- Clamp: same as above but step = 25, dwell = 0 → inc_out sequence 100, 125, 130, then done. 130 is never exceeded.
- Triangle: step = 10, dwell = 0, mode = 2 → inc_out 100, 110, 120, 130, 120, 110, 100, 110, … with dir toggling at 130 and 100. sync_out only in cycle 1. busy stays 1.
- Sawtooth: mode = 1, dwell = 0 → inc_out 100, 110, 120, 130, 100, … with sync_out = 1 in each cycle that inc_out returns to 100.
- Abort and ignore:
  - stop at cycle 5 of the single sweep → busy = 0 in cycle 6, done never pulses, inc_out holds 110.
  - start and stop asserted together in IDLE → no sweep.
  - start during a sweep → ignored.
- Reset mid-sweep: assert rst asynchronously during DWELL → outputs go to 0 immediately without waiting for a clock edge; a fresh start afterwards sweeps normally. (With SWEEP_HOLD_EN: hold for 4 cycles extends that step by exactly 4 cycles.)
